// File: rtl/speed_pkg.sv
// Speed-mode encodings shared by the speed controller and the display read-out.
package speed_pkg;

    localparam int unsigned SPEED_W = 2;

    typedef logic [SPEED_W-1:0] speed_t;

    localparam speed_t SPD_SLOW = 2'd0;
    localparam speed_t SPD_MED  = 2'd1;
    localparam speed_t SPD_FAST = 2'd2;
    localparam speed_t SPD_MAX  = 2'd3;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronises an active-low button, debounces it, and pulses once per accepted press.
module btn_debouncer #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

    logic           sync1_q, sync2_q;
    logic           level_q, level_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           press_q, press_d;

    // Any run of differing samples shorter than DB_CYCLES restarts the count.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DbLast) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= ~btn_ni;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/debounced_speed_ctrl.sv
// Button-stepped speed mode with a single-clock count-enable tick at the selected period.
module debounced_speed_ctrl
    import speed_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned DIV0      = 50000000,
    parameter int unsigned DIV1      = 25000000,
    parameter int unsigned DIV2      = 12500000,
    parameter int unsigned DIV3      = 6250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn,
    output logic [SPEED_W-1:0] speed_sel,
    output logic               press,
    output logic               tick
);

    localparam int unsigned DivMax = max4(DIV0, DIV1, DIV2, DIV3);
    localparam int unsigned CntW   = $clog2(DivMax + 1);

    localparam logic [CntW-1:0] Term0 = CntW'(DIV0 - 1);
    localparam logic [CntW-1:0] Term1 = CntW'(DIV1 - 1);
    localparam logic [CntW-1:0] Term2 = CntW'(DIV2 - 1);
    localparam logic [CntW-1:0] Term3 = CntW'(DIV3 - 1);

    speed_t          speed_q, speed_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [CntW-1:0] term;
    logic            press_w;

    btn_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debouncer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .btn_ni  (btn),
        .press_o (press_w)
    );

    always_comb begin
        term = Term0;
        unique case (speed_q)
            SPD_SLOW: term = Term0;
            SPD_MED:  term = Term1;
            SPD_FAST: term = Term2;
            SPD_MAX:  term = Term3;
            default:  term = Term0;
        endcase
    end

    assign tick = (div_cnt_q == term);

    // A mode change restarts the period; a tick in the same cycle still completes the old one.
    always_comb begin
        speed_d   = speed_q;
        div_cnt_d = div_cnt_q + CntW'(1);
        if (press_w) begin
            speed_d   = speed_q + SPEED_W'(1);
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_q   <= SPD_SLOW;
            div_cnt_q <= '0;
        end else begin
            speed_q   <= speed_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign speed_sel = speed_q;
    assign press     = press_w;

endmodule

// File: tb/tb_debounced_speed_ctrl.sv
// Randomised and directed bench for debounced_speed_ctrl against a window/phase model.
module tb_debounced_speed_ctrl;

    localparam int DB = 4;
    int divs[4] = '{8, 4, 2, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b1;
    logic [1:0] speed_sel;
    logic       press;
    logic       tick;

    int total = 0;
    int bad = 0;

    debounced_speed_ctrl #(
        .DB_CYCLES (4),
        .DIV0      (8),
        .DIV1      (4),
        .DIV2      (2),
        .DIV3      (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .speed_sel (speed_sel),
        .press     (press),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: sampled pressed-levels reach the debouncer two edges late; the level flips once
    // the last DB samples all disagree with it; the tick phase restarts on every mode change.
    bit bq[$];
    bit dq[$];
    bit m_lvl;
    bit m_press;
    int m_mode;
    int m_phase;

    initial begin
        bq = '{1'b0, 1'b0};
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                bq = '{1'b0, 1'b0};
                dq.delete();
                m_lvl = 1'b0;
                m_press = 1'b0;
                m_mode = 0;
                m_phase = 0;
            end else begin : step
                bit d;
                bit rose;
                bit all_diff;
                d = bq.pop_front();
                bq.push_back(!btn);
                dq.push_back(d);
                if (dq.size() > DB) void'(dq.pop_front());
                all_diff = (dq.size() == DB);
                foreach (dq[i]) if (dq[i] == m_lvl) all_diff = 1'b0;
                rose = 1'b0;
                if (all_diff) begin
                    rose = !m_lvl;
                    m_lvl = !m_lvl;
                end
                if (m_press) begin
                    m_mode = (m_mode + 1) % 4;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
                m_press = rose;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_speed_sel", int'(speed_sel), m_mode);
            check("model_press", int'(press), int'(m_press));
            check("model_tick", int'(tick),
                  int'((m_phase % divs[m_mode]) == divs[m_mode] - 1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 64);
    endtask

    task automatic wait_press(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!press && n < 64);
    endtask

    task automatic do_press(input int exp_sel);
        int n;
        btn = 1'b0;
        wait_press(n);
        check("press_latency", n, 6);
        cyc(1);
        check("press_sel", int'(speed_sel), exp_sel);
        btn = 1'b1;
        cyc(8);
    endtask

    initial begin
        int n;
        int cnt;
        reset = 1'b0;
        btn = 1'b1;
        cyc(3);
        check("reset_sel", int'(speed_sel), 0);
        check("reset_press", int'(press), 0);
        check("reset_tick", int'(tick), 0);
        reset = 1'b1;
        wait_tick(n);
        check("first_tick", n, 7);
        wait_tick(n);
        check("period0", n, 8);

        btn = 1'b0;
        cyc(3);
        btn = 1'b1;
        cyc(12);
        check("glitch_sel", int'(speed_sel), 0);

        btn = 1'b0;
        wait_press(n);
        check("first_press_latency", n, 6);
        @(negedge clk);
        check("sel_after_press", int'(speed_sel), 1);
        check("press_single", int'(press), 0);
        wait_tick(n);
        check("restart_tick1", n, 3);
        wait_tick(n);
        check("period1", n, 4);
        cyc(10);
        check("held_no_repress", int'(speed_sel), 1);
        btn = 1'b1;
        cyc(10);

        do_press(2);
        wait_tick(n);
        wait_tick(n);
        check("period2", n, 2);
        do_press(3);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        check("mode3_every_cycle", cnt, 5);
        do_press(0);
        wait_tick(n);
        wait_tick(n);
        check("period0_after_wrap", n, 8);

        // Line the press up with the mode-0 terminal count.
        wait_tick(n);
        cyc(2);
        btn = 1'b0;
        wait_press(n);
        check("tc_press_latency", n, 6);
        check("tick_on_press", int'(tick), 1);
        wait_tick(n);
        check("tick_after_change", n, 4);
        btn = 1'b1;
        cyc(10);

        repeat (150) begin
            btn = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 10));
        end
        btn = 1'b1;
        cyc(10);

        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        do_press(1);
        btn = 1'b0;
        wait_press(n);
        cyc(2);
        check("pre_reset_sel", int'(speed_sel), 2);
        check("pre_reset_tick", int'(tick), 1);
        #2 reset = 1'b0;
        #1;
        check("async_sel", int'(speed_sel), 0);
        check("async_press", int'(press), 0);
        check("async_tick", int'(tick), 0);
        @(negedge clk);
        reset = 1'b1;
        wait_press(n);
        check("post_reset_press", n, 6);
        @(negedge clk);
        check("post_reset_sel", int'(speed_sel), 1);
        btn = 1'b1;
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
